// File: rtl/bridge_arbiter.sv
// bridge_arbiter
//   Shares one downstream bridge target between NUM_REQ bridge-style
//   requesters (e.g. the APF host bridge and a core-side loader). Every
//   wr/rd pulse is captured into a one-deep slot per requester. A scheduler
//   replays at most one captured transaction per cycle onto the target port.
//   Read data comes back through a fixed-latency tag pipeline and is routed
//   to the requester that issued the read.
//
//   Optional feature macro: BRIDGE_ARBITER_FIXED_PRIO_EN
//     defined   -> fixed priority; the lowest pending index always wins.
//     undefined -> round-robin; the search starts after the last grant.
//
// Parameters
//   NUM_REQ       number of requesters (2..8)
//   READ_LATENCY  cycles from tgt_rd high to valid tgt_rd_data (1..8)
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   req_addr/req_wr_data    per-requester address / write data, [32*i +: 32]
//   req_wr/req_rd           per-requester single-cycle write / read pulses
//   req_rd_data/_valid      returned read data and its one-cycle strobe
//   req_pending             slot i holds an unissued transaction
//   req_overflow            sticky: a pulse to requester i was dropped
//   tgt_*                   shared downstream bridge target port

`default_nettype none

module bridge_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int READ_LATENCY = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ*32-1:0]  req_addr,
    input  logic [NUM_REQ*32-1:0]  req_wr_data,
    input  logic [NUM_REQ-1:0]     req_wr,
    input  logic [NUM_REQ-1:0]     req_rd,
    output logic [NUM_REQ*32-1:0]  req_rd_data,
    output logic [NUM_REQ-1:0]     req_rd_valid,
    output logic [NUM_REQ-1:0]     req_pending,
    output logic [NUM_REQ-1:0]     req_overflow,
    output logic [31:0]            tgt_addr,
    output logic [31:0]            tgt_wr_data,
    output logic                   tgt_wr,
    output logic                   tgt_rd,
    input  logic [31:0]            tgt_rd_data
);

    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] slot_valid;
    logic [NUM_REQ-1:0] slot_is_wr;
    logic [31:0]        slot_addr [NUM_REQ];
    logic [31:0]        slot_data [NUM_REQ];

    logic               grant_any;
    logic [ID_W-1:0]    grant_id;
    logic [NUM_REQ-1:0] grant_vec;
    logic [NUM_REQ-1:0] pulse;
    logic [NUM_REQ-1:0] take;

    logic [ID_W-1:0]         issue_id;
    logic [READ_LATENCY-1:0] tag_valid;
    logic [ID_W-1:0]         tag_id [READ_LATENCY];

`ifndef BRIDGE_ARBITER_FIXED_PRIO_EN
    logic [ID_W-1:0] rr_ptr;
`endif

    // Grant selection over pending slots. Candidates are visited from the
    // lowest priority to the highest so the last match is the winner.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
`ifdef BRIDGE_ARBITER_FIXED_PRIO_EN
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (slot_valid[i]) begin
                grant_any = 1'b1;
                grant_id  = ID_W'(i);
            end
        end
`else
        // Distance k from the pointer: k = 1 is the first slot after the
        // last grant, k = NUM_REQ is the last granted slot itself.
        for (int k = NUM_REQ; k >= 1; k--) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (slot_valid[i] && (((int'(rr_ptr) + k) % NUM_REQ) == i)) begin
                    grant_any = 1'b1;
                    grant_id  = ID_W'(i);
                end
            end
        end
`endif
    end

    assign grant_vec   = grant_any ? (NUM_REQ'(1) << grant_id) : '0;
    assign pulse       = req_wr | req_rd;
    // A slot accepts a pulse when empty or when it is being drained this cycle.
    assign take        = pulse & (~slot_valid | grant_vec);
    assign req_pending = slot_valid;

    // Slot capture, drain and sticky overflow. A simultaneous wr+rd keeps
    // the write and counts the lost read as an overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_valid   <= '0;
            slot_is_wr   <= '0;
            req_overflow <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                slot_addr[i] <= '0;
                slot_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (take[i]) begin
                    slot_valid[i] <= 1'b1;
                    slot_is_wr[i] <= req_wr[i];
                    slot_addr[i]  <= req_addr[32*i +: 32];
                    slot_data[i]  <= req_wr_data[32*i +: 32];
                end else if (grant_vec[i]) begin
                    slot_valid[i] <= 1'b0;
                end
                if ((pulse[i] && !take[i]) || (req_wr[i] && req_rd[i])) begin
                    req_overflow[i] <= 1'b1;
                end
            end
        end
    end

    // Target issue register. Address and data hold their last values while
    // idle; the strobes are high only for the cycle after a grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tgt_wr      <= 1'b0;
            tgt_rd      <= 1'b0;
            tgt_addr    <= '0;
            tgt_wr_data <= '0;
            issue_id    <= '0;
`ifndef BRIDGE_ARBITER_FIXED_PRIO_EN
            rr_ptr      <= ID_W'(NUM_REQ - 1);
`endif
        end else begin
            tgt_wr <= grant_any && slot_is_wr[grant_id];
            tgt_rd <= grant_any && !slot_is_wr[grant_id];
            if (grant_any) begin
                tgt_addr    <= slot_addr[grant_id];
                tgt_wr_data <= slot_data[grant_id];
                issue_id    <= grant_id;
`ifndef BRIDGE_ARBITER_FIXED_PRIO_EN
                rr_ptr      <= grant_id;
`endif
            end
        end
    end

    // Read tag pipeline, fed from the registered strobe so the last stage
    // lines up with the cycle in which the target presents read data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_valid <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                tag_id[i] <= '0;
            end
        end else begin
            tag_valid[0] <= tgt_rd;
            tag_id[0]    <= issue_id;
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_id[i]    <= tag_id[i-1];
            end
        end
    end

    // Read return routing: sample the target data into the owning
    // requester's register and strobe its valid for one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_rd_data  <= '0;
            req_rd_valid <= '0;
        end else begin
            req_rd_valid <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (tag_valid[READ_LATENCY-1] && (tag_id[READ_LATENCY-1] == ID_W'(i))) begin
                    req_rd_valid[i]        <= 1'b1;
                    req_rd_data[32*i +: 32] <= tgt_rd_data;
                end
            end
        end
    end

endmodule

`default_nettype wire
